spi_sf_responder: RTL and testbench

Synthesizable Quad-SPI serial-flash responder: the target-side counterpart of the quad-SPI flash controller. It watches the flash pins (c, s, dq) driven by the controller, decodes command/address/dummy phases and serves reads and page programs from a small internal memory. It is used in loopback builds and benches, in place of the external flash.

---
 rtl/spi_sf_responder.sv | 205 ++++++++++++++++++++
 tb/tb_spi_sf_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sf_responder.sv
// Quad-SPI serial-flash responder. It decodes the controller's command, address and dummy
// phases and serves reads and page programs from a small register-based memory.
module spi_sf_responder #(
  parameter int unsigned MEM_AW     = 8,
  parameter int unsigned DUMMY_CLKS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sf_c,
  input  logic       sf_s,
  input  logic [3:0] sf_dq_i,
  output logic [3:0] sf_dq_o,
  output logic [3:0] sf_dq_t,
  output logic [7:0] last_cmd,
  output logic       wel,
  output logic       bad_cmd
);

  localparam int unsigned Depth = 1 << MEM_AW;

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StDummy, StRdata, StWdata, StStatus, StIgnore
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        c_sync_q, s_sync_q;
  logic [3:0]        dq_sync0_q, dq_sync1_q;
  logic              c_prev_q;
  logic [15:0]       cnt_q, cnt_d;
  logic [2:0]        ocnt_q, ocnt_d;
  logic [7:0]        rx_q, rx_d, tx_q, tx_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [3:0]        dq_o_q, dq_o_d;
  logic              wel_q, wel_d, bad_q, bad_d;
  logic [7:0]        last_cmd_q, last_cmd_d;
  logic [7:0]        mem_q [Depth];
  logic              mem_we;
  logic [7:0]        mem_wdata;

  logic       sck_rise, sck_fall, selected, quad, byte_done;
  logic [3:0] din;
  logic [7:0] rx_single, rx_quad, cur_byte;

  assign sck_rise  = c_sync_q[1] & ~c_prev_q;
  assign sck_fall  = ~c_sync_q[1] & c_prev_q;
  assign selected  = ~s_sync_q[1];
  assign din       = dq_sync1_q;
  assign quad      = (last_cmd_q == 8'h6B) || (last_cmd_q == 8'h32);
  assign rx_single = {rx_q[6:0], din[0]};
  assign rx_quad   = {rx_q[3:0], din};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_sync_q   <= '0;
      s_sync_q   <= 2'b11;
      dq_sync0_q <= '0;
      dq_sync1_q <= '0;
      c_prev_q   <= 1'b0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      ocnt_q     <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      addr_q     <= '0;
      dq_o_q     <= '0;
      wel_q      <= 1'b0;
      bad_q      <= 1'b0;
      last_cmd_q <= '0;
    end else begin
      c_sync_q   <= {c_sync_q[0], sf_c};
      s_sync_q   <= {s_sync_q[0], sf_s};
      dq_sync0_q <= sf_dq_i;
      dq_sync1_q <= dq_sync0_q;
      c_prev_q   <= c_sync_q[1];
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ocnt_q     <= ocnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      addr_q     <= addr_d;
      dq_o_q     <= dq_o_d;
      wel_q      <= wel_d;
      bad_q      <= bad_d;
      last_cmd_q <= last_cmd_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_q] <= mem_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ocnt_d     = ocnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    addr_d     = addr_q;
    dq_o_d     = dq_o_q;
    wel_d      = wel_q;
    bad_d      = bad_q;
    last_cmd_d = last_cmd_q;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    cur_byte   = '0;
    byte_done  = 1'b0;
    if (!selected) begin
      state_d = StIdle;
      cnt_d   = '0;
      ocnt_d  = '0;
      if (state_q == StWdata) wel_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StCmd: begin
          state_d = StCmd;
          if (sck_rise) begin
            rx_d  = rx_single;
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == 16'd7) begin
              cnt_d      = '0;
              last_cmd_d = rx_single;
              case (rx_single)
                8'h06: begin wel_d = 1'b1; state_d = StIgnore; end
                8'h04: begin wel_d = 1'b0; state_d = StIgnore; end
                8'h05: state_d = StStatus;
                8'h03, 8'h6B, 8'h02, 8'h32: state_d = StAddr;
                default: begin bad_d = 1'b1; state_d = StIgnore; end
              endcase
            end
          end
        end
        StAddr: begin
          if (sck_rise) begin
            addr_d = {addr_q[MEM_AW-2:0], din[0]};
            cnt_d  = cnt_q + 16'd1;
            if (cnt_q == 16'd23) begin
              cnt_d = '0;
              if (last_cmd_q == 8'h6B)      state_d = (DUMMY_CLKS == 0) ? StRdata : StDummy;
              else if (last_cmd_q == 8'h03) state_d = StRdata;
              else                          state_d = StWdata;
            end
          end
        end
        StDummy: begin
          if (sck_rise) begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == 16'(DUMMY_CLKS - 1)) begin
              cnt_d   = '0;
              state_d = StRdata;
            end
          end
        end
        StRdata, StStatus: begin
          // A fresh byte is fetched on the first fall of each byte, then shifted out.
          if (sck_fall) begin
            if (ocnt_q != 3'd0)          cur_byte = tx_q;
            else if (state_q == StStatus) cur_byte = {6'b0, wel_q, 1'b0};
            else                         cur_byte = mem_q[addr_q];
            if (quad && state_q == StRdata) begin
              dq_o_d    = cur_byte[7:4];
              tx_d      = {cur_byte[3:0], 4'b0};
              byte_done = (ocnt_q == 3'd1);
            end else begin
              dq_o_d    = {2'b0, cur_byte[7], 1'b0};
              tx_d      = {cur_byte[6:0], 1'b0};
              byte_done = (ocnt_q == 3'd7);
            end
            ocnt_d = byte_done ? 3'd0 : ocnt_q + 3'd1;
            if (byte_done && state_q == StRdata) addr_d = addr_q + MEM_AW'(1);
          end
        end
        StWdata: begin
          if (sck_rise) begin
            rx_d      = quad ? rx_quad : rx_single;
            byte_done = quad ? (cnt_q == 16'd1) : (cnt_q == 16'd7);
            cnt_d     = byte_done ? 16'd0 : cnt_q + 16'd1;
            if (byte_done && wel_q) begin
              mem_we    = 1'b1;
              mem_wdata = rx_d;
              addr_d    = addr_q + MEM_AW'(1);
            end
          end
        end
        StIgnore: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    sf_dq_t = 4'b1111;
    if (state_q == StRdata && quad)                      sf_dq_t = 4'b0000;
    else if (state_q == StRdata || state_q == StStatus) sf_dq_t = 4'b1101;
  end

  assign sf_dq_o  = dq_o_q;
  assign last_cmd = last_cmd_q;
  assign wel      = wel_q;
  assign bad_cmd  = bad_q;

endmodule

// File: tb/tb_spi_sf_responder.sv
// Directed bench for spi_sf_responder: a bit-level controller model drives SCK at clk/8
// and checks memory, status and pin behaviour against hand-computed values.
module tb_spi_sf_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       sf_c, sf_s;
  logic [3:0] sf_dq_i, sf_dq_o, sf_dq_t;
  logic [7:0] last_cmd;
  logic       wel, bad_cmd;

  int checks = 0;
  int failures = 0;

  spi_sf_responder #(.MEM_AW(8), .DUMMY_CLKS(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .sf_c     (sf_c),
    .sf_s     (sf_s),
    .sf_dq_i  (sf_dq_i),
    .sf_dq_o  (sf_dq_o),
    .sf_dq_t  (sf_dq_t),
    .last_cmd (last_cmd),
    .wel      (wel),
    .bad_cmd  (bad_cmd)
  );

  always #5 clk = ~clk;

  // One SCK period: data set while low, responder output captured just before the rise.
  task automatic sck(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] tout);
    sf_dq_i = din;
    repeat (4) @(negedge clk);
    dout = sf_dq_o;
    tout = sf_dq_t;
    sf_c = 1'b1;
    repeat (4) @(negedge clk);
    sf_c = 1'b0;
  endtask

  task automatic select_dev();
    sf_s = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic deselect_dev();
    repeat (4) @(negedge clk);
    sf_s = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit quad);
    logic [3:0] d, t;
    if (quad) begin
      sck(b[7:4], d, t);
      sck(b[3:0], d, t);
    end else begin
      for (int i = 7; i >= 0; i--) sck({3'b0, b[i]}, d, t);
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [3:0] d, t;
    for (int i = 23; i >= 0; i--) sck({3'b0, a[i]}, d, t);
  endtask

  task automatic recv_byte(input bit quad, output logic [7:0] b, output logic [3:0] t);
    logic [3:0] d;
    if (quad) begin
      sck(4'h0, d, t);
      b[7:4] = d;
      sck(4'h0, d, t);
      b[3:0] = d;
    end else begin
      for (int i = 7; i >= 0; i--) begin
        sck(4'h0, d, t);
        b[i] = d[1];
      end
    end
  endtask

  task automatic cmd_only(input logic [7:0] op);
    select_dev();
    send_byte(op, 1'b0);
    deselect_dev();
  endtask

  task automatic read_single(input logic [7:0] a, output logic [7:0] b);
    logic [3:0] t;
    select_dev();
    send_byte(8'h03, 1'b0);
    send_addr({16'h0, a});
    recv_byte(1'b0, b, t);
    deselect_dev();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sf_s = 1'b1;
    sf_c = 1'b0;
    sf_dq_i = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (sf_dq_o !== 4'h0) begin failures++; $display("FAIL reset_dq_o got %h want 0", sf_dq_o); end
    checks++; if (sf_dq_t !== 4'hF) begin failures++; $display("FAIL reset_dq_t got %b want 1111", sf_dq_t); end
    checks++; if (last_cmd !== 8'h00) begin failures++; $display("FAIL reset_last_cmd got %h want 00", last_cmd); end
    checks++; if (wel !== 1'b0) begin failures++; $display("FAIL reset_wel got %b want 0", wel); end
    checks++; if (bad_cmd !== 1'b0) begin failures++; $display("FAIL reset_bad_cmd got %b want 0", bad_cmd); end
  endtask

  task automatic test_single_write();
    cmd_only(8'h06);
    checks++; if (wel !== 1'b1) begin failures++; $display("FAIL wren_wel got %b want 1", wel); end
    checks++; if (last_cmd !== 8'h06) begin failures++; $display("FAIL wren_last_cmd got %h want 06", last_cmd); end
    select_dev();
    send_byte(8'h02, 1'b0);
    send_addr(24'h000010);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    deselect_dev();
    checks++; if (wel !== 1'b0) begin failures++; $display("FAIL pp_wel_clear got %b want 0", wel); end
  endtask

  task automatic test_single_read();
    logic [7:0] b;
    logic [3:0] t;
    select_dev();
    send_byte(8'h03, 1'b0);
    send_addr(24'h000010);
    recv_byte(1'b0, b, t);
    checks++; if (b !== 8'hA5) begin failures++; $display("FAIL read_byte0 got %h want a5", b); end
    checks++; if (t !== 4'b1101) begin failures++; $display("FAIL read_dq_t got %b want 1101", t); end
    recv_byte(1'b0, b, t);
    checks++; if (b !== 8'h5A) begin failures++; $display("FAIL read_byte1 got %h want 5a", b); end
    deselect_dev();
    checks++; if (sf_dq_t !== 4'hF) begin failures++; $display("FAIL read_desel_dq_t got %b want 1111", sf_dq_t); end
  endtask

  task automatic test_quad();
    logic [7:0] b;
    logic [3:0] t, d;
    cmd_only(8'h06);
    select_dev();
    send_byte(8'h32, 1'b0);
    send_addr(24'h0000FF);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    deselect_dev();
    select_dev();
    send_byte(8'h6B, 1'b0);
    send_addr(24'h0000FF);
    for (int i = 0; i < 8; i++) sck(4'h0, d, t);
    recv_byte(1'b1, b, t);
    checks++; if (b !== 8'h12) begin failures++; $display("FAIL quad_read0 got %h want 12", b); end
    checks++; if (t !== 4'b0000) begin failures++; $display("FAIL quad_dq_t got %b want 0000", t); end
    recv_byte(1'b1, b, t);
    checks++; if (b !== 8'h34) begin failures++; $display("FAIL quad_read1 got %h want 34", b); end
    deselect_dev();
    read_single(8'h00, b);
    checks++; if (b !== 8'h34) begin failures++; $display("FAIL quad_wrap got %h want 34", b); end
  endtask

  task automatic test_wel_status();
    logic [7:0] b;
    logic [3:0] t;
    select_dev();
    send_byte(8'h02, 1'b0);
    send_addr(24'h000020);
    send_byte(8'h77, 1'b0);
    deselect_dev();
    read_single(8'h20, b);
    checks++; if (b !== 8'h00) begin failures++; $display("FAIL nowel_write got %h want 00", b); end
    select_dev();
    send_byte(8'h05, 1'b0);
    recv_byte(1'b0, b, t);
    deselect_dev();
    checks++; if (b !== 8'h00) begin failures++; $display("FAIL status_idle got %h want 00", b); end
    cmd_only(8'h06);
    select_dev();
    send_byte(8'h05, 1'b0);
    recv_byte(1'b0, b, t);
    recv_byte(1'b0, b, t);
    deselect_dev();
    checks++; if (b !== 8'h02) begin failures++; $display("FAIL status_wel got %h want 02", b); end
    cmd_only(8'h04);
    checks++; if (wel !== 1'b0) begin failures++; $display("FAIL wrdi_wel got %b want 0", wel); end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] b;
    logic [3:0] t, d;
    select_dev();
    send_byte(8'h9F, 1'b0);
    sck(4'h0, d, t);
    sck(4'h0, d, t);
    checks++; if (bad_cmd !== 1'b1) begin failures++; $display("FAIL bad_cmd_set got %b want 1", bad_cmd); end
    checks++; if (last_cmd !== 8'h9F) begin failures++; $display("FAIL bad_last_cmd got %h want 9f", last_cmd); end
    checks++; if (t !== 4'hF) begin failures++; $display("FAIL bad_dq_t got %b want 1111", t); end
    deselect_dev();
    select_dev();
    for (int i = 0; i < 3; i++) sck(4'h1, d, t);
    deselect_dev();
    read_single(8'h10, b);
    checks++; if (b !== 8'hA5) begin failures++; $display("FAIL partial_recover got %h want a5", b); end
    checks++; if (last_cmd !== 8'h03) begin failures++; $display("FAIL partial_last_cmd got %h want 03", last_cmd); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    logic [3:0] t, d;
    cmd_only(8'h06);
    select_dev();
    send_byte(8'h03, 1'b0);
    send_addr(24'h000010);
    for (int i = 0; i < 4; i++) sck(4'h0, d, t);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (sf_dq_o !== 4'h0) begin failures++; $display("FAIL mid_dq_o got %h want 0", sf_dq_o); end
    checks++; if (sf_dq_t !== 4'hF) begin failures++; $display("FAIL mid_dq_t got %b want 1111", sf_dq_t); end
    checks++; if (wel !== 1'b0) begin failures++; $display("FAIL mid_wel got %b want 0", wel); end
    checks++; if (bad_cmd !== 1'b0) begin failures++; $display("FAIL mid_bad_cmd got %b want 0", bad_cmd); end
    checks++; if (last_cmd !== 8'h00) begin failures++; $display("FAIL mid_last_cmd got %h want 00", last_cmd); end
    sf_s = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    read_single(8'h10, b);
    checks++; if (b !== 8'h00) begin failures++; $display("FAIL mid_mem_clear got %h want 00", b); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_quad();
    test_wel_status();
    test_bad_cmd();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
